mask_encode32: RTL and testbench



---
 rtl/mask_encode32_pkg.sv | 22 ++
 rtl/mask_encode32_pri_enc32.sv | 25 ++
 rtl/mask_encode32.sv | 115 +++++++++++
 tb/tb_mask_encode32.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_encode32_pkg.sv
// Shared widths, FSM state encoding and a popcount helper for mask_encode32.
package mask_encode32_pkg;

    localparam int MASK_W = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] m);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MASK_W; i++) begin
            cnt = cnt + CNT_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mask_encode32_pri_enc32.sv
// Combinational 32-bit priority encoder: lowest set bit index, any-set and exactly-one-set flags.
module pri_enc32
    import mask_encode32_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  index,
    output logic              any,
    output logic              single
);

    always_comb begin
        // NOTE: index is defaulted before the loop so no input pattern leaves it unassigned (no latch).
        index = '0;
        // Scan high-to-low so the lowest set bit is the last (winning) assignment.
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign any    = |mask;
    assign single = any && ((mask & (mask - MASK_W'(1))) == '0);

endmodule

// File: rtl/mask_encode32.sv
// Sequential 32-to-5 mask encoder: emits each set bit's index in ascending order, one per handshake.
// Optional pop_count output is enabled by defining MASK_ENCODE32_POPCOUNT_EN.
module mask_encode32
    import mask_encode32_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [MASK_W-1:0] in_mask,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              zero_mask,
`ifdef MASK_ENCODE32_POPCOUNT_EN
    output logic [CNT_W-1:0]  pop_count,
`endif
    output logic              busy
);

    state_e            state_q, state_d;
    logic [MASK_W-1:0] remaining_q, remaining_d;
    logic              zero_mask_q, zero_mask_d;

    logic [IDX_W-1:0]  rem_index;
    logic              rem_any;
    logic              rem_single;

    // Outputs depend only on remaining, never on in_* or out_ready.
    pri_enc32 u_pri_enc (
        .mask   (remaining_q),
        .index  (rem_index),
        .any    (rem_any),
        .single (rem_single)
    );

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SCAN);
    assign out_valid = (state_q == SCAN) && rem_any;
    assign out_index = rem_index;
    assign out_last  = (state_q == SCAN) && rem_single;
    assign zero_mask = zero_mask_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        zero_mask_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_mask != '0) begin
                        remaining_d = in_mask;
                        state_d     = SCAN;
                    end else begin
                        zero_mask_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_fire) begin
                    if (out_last) begin
                        remaining_d = '0;
                        state_d     = IDLE;
                    end else begin
                        // Clearing the lowest set bit is exactly clearing the emitted index.
                        remaining_d = remaining_q & (remaining_q - MASK_W'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            zero_mask_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            zero_mask_q <= zero_mask_d;
        end
    end

`ifdef MASK_ENCODE32_POPCOUNT_EN
    logic [CNT_W-1:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        if (in_fire) begin
            pop_count_d = popcount(in_mask);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_mask_encode32.sv
// Self-checking bench for mask_encode32: queue-based model checked every cycle plus directed literal checks.
module tb_mask_encode32;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        zero_mask;
    logic        busy;
`ifdef MASK_ENCODE32_POPCOUNT_EN
    logic [5:0]  pop_count;
`endif

    mask_encode32 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_mask   (in_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .zero_mask (zero_mask),
`ifdef MASK_ENCODE32_POPCOUNT_EN
        .pop_count (pop_count),
`endif
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: pending indices of the mask being drained, plus idle/scan and zero pulse.
    int exp_q[$];
    bit m_scan;
    bit m_zero;
    int m_pop;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_scan = 1'b0;
            m_zero = 1'b0;
            m_pop  = 0;
        end else begin
            m_zero = 1'b0;
            if (!m_scan) begin
                if (in_valid) begin
                    m_pop = $countones(in_mask);
                    if (in_mask == 32'd0) begin
                        m_zero = 1'b1;
                    end else begin
                        for (int i = 0; i < 32; i++) begin
                            if (in_mask[i]) exp_q.push_back(i);
                        end
                        m_scan = 1'b1;
                    end
                end
            end else if (out_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_scan = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            check("in_ready", in_ready, !m_scan);
            check("out_valid", out_valid, m_scan);
            check("busy", busy, m_scan);
            check("zero_mask", zero_mask, m_zero);
            if (m_scan) begin
                check("out_index", out_index, exp_q[0]);
                check("out_last", out_last, exp_q.size() == 1);
            end else begin
                check("out_last_idle", out_last, 0);
            end
`ifdef MASK_ENCODE32_POPCOUNT_EN
            check("pop_count", pop_count, m_pop);
`endif
        end
    end

    // Record every completed output transfer for the directed literal checks.
    int obs_idx[$];
    bit obs_last[$];

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            obs_idx.push_back(int'(out_index));
            obs_last.push_back(out_last);
        end
    end

    task automatic clear_obs();
        obs_idx.delete();
        obs_last.delete();
    endtask

    task automatic send(input logic [31:0] m);
        bit acc;
        acc = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_mask  = m;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_mask  = '0;
        if (!acc) check("send_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (!m_scan) break;
        end
        check("drain_timeout", m_scan, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_zero_mask", zero_mask, 0);
        check("rst_busy", busy, 0);

        // Single bit.
        clear_obs();
        send(32'h0000_0001);
        wait_idle();
        check("single_count", obs_idx.size(), 1);
        if (obs_idx.size() == 1) begin
            check("single_idx", obs_idx[0], 0);
            check("single_last", obs_last[0], 1);
        end

        // Two bits at the extremes.
        clear_obs();
        send(32'h8000_0001);
        wait_idle();
        check("two_count", obs_idx.size(), 2);
        if (obs_idx.size() == 2) begin
            check("two_idx0", obs_idx[0], 0);
            check("two_last0", obs_last[0], 0);
            check("two_idx1", obs_idx[1], 31);
            check("two_last1", obs_last[1], 1);
        end

        // All bits.
        clear_obs();
        send(32'hFFFF_FFFF);
`ifdef MASK_ENCODE32_POPCOUNT_EN
        @(negedge clock);
        check("all_pop", pop_count, 32);
`endif
        wait_idle();
        check("all_count", obs_idx.size(), 32);
        if (obs_idx.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                check("all_idx", obs_idx[i], i);
                check("all_last", obs_last[i], i == 31);
            end
        end

        // Backpressure: index 4 held for three stalled edges.
        clear_obs();
        out_ready = 1'b0;
        send(32'h0000_0110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_hold_idx", out_index, 4);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_last", out_last, 0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_idle();
        check("bp_count", obs_idx.size(), 2);
        if (obs_idx.size() == 2) begin
            check("bp_idx0", obs_idx[0], 4);
            check("bp_idx1", obs_idx[1], 8);
        end

        // Zero mask.
        clear_obs();
        send(32'h0000_0000);
        @(negedge clock);
        check("zero_pulse", zero_mask, 1);
        check("zero_out_valid", out_valid, 0);
        check("zero_in_ready", in_ready, 1);
        @(negedge clock);
        check("zero_pulse_end", zero_mask, 0);
        check("zero_count", obs_idx.size(), 0);

        // Reset mid-scan after index 12 transfers.
        clear_obs();
        send(32'h0000_F000);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_index", out_index, 0);
        check("mrst_out_last", out_last, 0);
        check("mrst_busy", busy, 0);
        check("mrst_zero_mask", zero_mask, 0);
        check("mrst_seen", obs_idx.size(), 1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("mrst_in_ready", in_ready, 1);
        clear_obs();
        send(32'h0000_0004);
        wait_idle();
        check("post_rst_count", obs_idx.size(), 1);
        if (obs_idx.size() == 1) begin
            check("post_rst_idx", obs_idx[0], 2);
            check("post_rst_last", obs_last[0], 1);
        end

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
